// File: rtl/cmos_nvram_arbiter_if.sv
// rtl/cmos_nvram_arbiter_if.sv - CPU, HPS and RAM port bundle for the CMOS NVRAM arbiter
interface cmos_nvram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 4
);
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_pause;

    logic          hps_req;
    logic          hps_we;
    logic [AW-1:0] hps_addr;
    logic [7:0]    hps_din;
    logic [7:0]    hps_dout;
    logic          hps_ack;
    logic          hps_clr_dirty;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic          dirty;
    logic          busy;

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_pause,
        input  hps_req, hps_we, hps_addr, hps_din, hps_clr_dirty,
        output hps_dout, hps_ack,
        output ram_addr, ram_we, ram_din,
        input  ram_dout,
        output dirty, busy
    );

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_pause,
        output hps_req, hps_we, hps_addr, hps_din, hps_clr_dirty,
        input  hps_dout, hps_ack,
        input  ram_addr, ram_we, ram_din,
        output ram_dout,
        input  dirty, busy
    );
endinterface

// File: rtl/cmos_nvram_arbiter.sv
// rtl/cmos_nvram_arbiter.sv - CPU-priority arbiter sharing the CMOS NVRAM with the HPS ioctl path
module cmos_nvram_arbiter #(
    parameter int AW          = 10,
    parameter int DW          = 4,
    parameter int HPS_TIMEOUT = 255
) (
    input  logic                i_clk_sys,
    input  logic                i_reset,
    cmos_nvram_arbiter_if.slave bus
);
    localparam logic [7:0] TIMEOUT = 8'(HPS_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RDW,
        ST_ACK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_wait_cnt;
    logic [7:0]    w_wait_cnt_nxt;
    logic          r_cpu_pause;
    logic          w_cpu_pause_nxt;
    logic          w_launch;
    logic [AW-1:0] r_hps_addr_last;
    logic          r_cpu_rd_d;
    logic [DW-1:0] r_cpu_dout;
    logic [7:0]    r_hps_dout;
    logic          r_dirty;

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_cpu_pause_nxt = r_cpu_pause;
        w_launch        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.hps_req) begin
                    w_wait_cnt_nxt  = 8'd0;
                    w_cpu_pause_nxt = 1'b0;
                end else if (!bus.cpu_cs) begin
                    w_launch       = 1'b1;
                    w_wait_cnt_nxt = 8'd0;
                    w_state_nxt    = bus.hps_we ? ST_ACK : ST_RDW;
                end else begin
                    // CPU owns this cycle: age the request, force a pause once starved
                    if (r_wait_cnt < TIMEOUT) begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                    if (w_wait_cnt_nxt == TIMEOUT) begin
                        w_cpu_pause_nxt = 1'b1;
                    end
                end
            end
            ST_RDW:  w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_state_nxt == ST_ACK) begin
            w_cpu_pause_nxt = 1'b0;
        end
    end

    always_comb begin
        bus.ram_addr = r_hps_addr_last;
        bus.ram_we   = 1'b0;
        bus.ram_din  = bus.hps_din[DW-1:0];
        if (bus.cpu_cs) begin
            bus.ram_addr = bus.cpu_addr;
            bus.ram_we   = bus.cpu_we;
            bus.ram_din  = bus.cpu_din;
        end else if (w_launch) begin
            bus.ram_addr = bus.hps_addr;
            bus.ram_we   = bus.hps_we;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_wait_cnt      <= 8'd0;
            r_cpu_pause     <= 1'b0;
            r_hps_addr_last <= '0;
            r_cpu_rd_d      <= 1'b0;
            r_cpu_dout      <= '0;
            r_hps_dout      <= 8'd0;
            r_dirty         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_cpu_pause <= w_cpu_pause_nxt;
            if (w_launch) begin
                r_hps_addr_last <= bus.hps_addr;
            end
            r_cpu_rd_d <= bus.cpu_cs & ~bus.cpu_we;
            if (r_cpu_rd_d) begin
                r_cpu_dout <= bus.ram_dout;
            end
            // RAM output here belongs to the address presented in the launch cycle
            if (r_state == ST_RDW) begin
                r_hps_dout <= {{(8-DW){1'b0}}, bus.ram_dout};
            end
            if (bus.cpu_cs & bus.cpu_we) begin
                r_dirty <= 1'b1;
            end else if (bus.hps_clr_dirty) begin
                r_dirty <= 1'b0;
            end
        end
    end

    assign bus.cpu_dout  = r_cpu_dout;
    assign bus.cpu_pause = r_cpu_pause;
    assign bus.hps_dout  = r_hps_dout;
    assign bus.hps_ack   = (r_state == ST_ACK);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.dirty     = r_dirty;
endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
// tb/tb_cmos_nvram_arbiter.sv - randomized and directed bench for cmos_nvram_arbiter
module tb_cmos_nvram_arbiter;
    localparam int AW = 10;
    localparam int DW = 4;
    localparam int T  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmos_nvram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    cmos_nvram_arbiter #(.AW(AW), .DW(DW), .HPS_TIMEOUT(T)) dut (
        .i_clk_sys (clk),
        .i_reset   (rst),
        .bus       (bus)
    );

    logic [3:0] mem [1024];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic       s_cpu_cs, s_cpu_we, s_hps_req, s_hps_we, s_clr;
    logic [9:0] s_cpu_addr, s_hps_addr;
    logic [3:0] s_cpu_din;
    logic [7:0] s_hps_din;

    typedef struct {
        int         due;
        logic [3:0] val;
    } rd_t;
    rd_t        rdq[$];
    logic [3:0] shadow [1024];
    logic       m_inflight, m_hwe, m_dirty, m_pause, m_acked;
    int         m_ack_cyc, m_waits;
    logic [3:0] m_rd_val, m_cpu_dout;
    logic [7:0] m_hps_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0; m_hwe = 0; m_dirty = 0; m_pause = 0; m_acked = 0;
        m_ack_cyc = -1; m_waits = 0; m_rd_val = 0; m_cpu_dout = 0; m_hps_dout = 0;
        rdq.delete();
    endtask

    task automatic idle_inputs();
        s_cpu_cs = 0; s_cpu_we = 0; s_cpu_addr = 0; s_cpu_din = 0;
        s_hps_req = 0; s_hps_we = 0; s_hps_addr = 0; s_hps_din = 0; s_clr = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_din = 0;
        bus.hps_req = 0; bus.hps_we = 0; bus.hps_addr = 0; bus.hps_din = 0;
        bus.hps_clr_dirty = 0;
        rst = 1;
        @(posedge clk); #1;
        cyc++;
        rst = 0;
        model_reset();
    endtask

    // One clock: check registered outputs, drive stimulus, check the RAM mux, advance the model.
    task automatic run_cycle();
        logic launch, idle_now;
        while (rdq.size() > 0 && rdq[0].due == cyc) begin
            m_cpu_dout = rdq[0].val;
            void'(rdq.pop_front());
        end
        m_acked = m_inflight && (cyc == m_ack_cyc);
        if (m_acked) begin
            m_pause = 0;
            if (!m_hwe) m_hps_dout = {4'h0, m_rd_val};
        end
        chk("hps_ack",   bus.hps_ack,   m_acked);
        chk("busy",      bus.busy,      m_inflight);
        chk("cpu_pause", bus.cpu_pause, m_pause);
        chk("dirty",     bus.dirty,     m_dirty);
        chk("cpu_dout",  bus.cpu_dout,  m_cpu_dout);
        chk("hps_dout",  bus.hps_dout,  m_hps_dout);

        bus.cpu_cs = s_cpu_cs; bus.cpu_we = s_cpu_we; bus.cpu_addr = s_cpu_addr;
        bus.cpu_din = s_cpu_din; bus.hps_req = s_hps_req; bus.hps_we = s_hps_we;
        bus.hps_addr = s_hps_addr; bus.hps_din = s_hps_din; bus.hps_clr_dirty = s_clr;
        #1;
        launch   = s_hps_req && !s_cpu_cs && !m_inflight;
        idle_now = !m_inflight;
        if (s_cpu_cs) begin
            chk("ram_addr_cpu", bus.ram_addr, s_cpu_addr);
            chk("ram_we_cpu",   bus.ram_we,   s_cpu_we);
            if (s_cpu_we) chk("ram_din_cpu", bus.ram_din, s_cpu_din);
        end else if (launch) begin
            chk("ram_addr_hps", bus.ram_addr, s_hps_addr);
            chk("ram_we_hps",   bus.ram_we,   s_hps_we);
            if (s_hps_we) chk("ram_din_hps", bus.ram_din, s_hps_din[3:0]);
        end else begin
            chk("ram_we_idle", bus.ram_we, 1'b0);
        end

        if (s_cpu_cs && s_cpu_we) begin
            shadow[s_cpu_addr] = s_cpu_din;
            m_dirty = 1;
        end else if (s_clr) begin
            m_dirty = 0;
        end
        if (s_cpu_cs && !s_cpu_we) rdq.push_back('{cyc + 2, shadow[s_cpu_addr]});
        if (m_acked) m_inflight = 0;
        if (launch) begin
            m_inflight = 1;
            m_hwe      = s_hps_we;
            m_ack_cyc  = cyc + (s_hps_we ? 1 : 2);
            m_rd_val   = shadow[s_hps_addr];
            if (s_hps_we) shadow[s_hps_addr] = s_hps_din[3:0];
            m_waits    = 0;
        end else if (idle_now && !m_acked) begin
            if (!s_hps_req) begin
                m_waits = 0;
                m_pause = 0;
            end else if (s_cpu_cs) begin
                if (m_waits < T) m_waits++;
                if (m_waits >= T) m_pause = 1;
            end
        end

        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic wait_ack(input int limit);
        logic seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            run_cycle();
            seen = m_acked;
        end
        chk("ack_within_bound", seen, 1'b1);
        s_hps_req = 0;
    endtask

    task automatic hps_txn(input logic we, input logic [9:0] addr, input logic [7:0] din);
        s_hps_req = 1; s_hps_we = we; s_hps_addr = addr; s_hps_din = din;
        wait_ack(6);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 4'h0;
            shadow[i] = 4'h0;
        end
        apply_reset();
        repeat (2) run_cycle();

        // HPS write with the CPU idle
        hps_txn(1'b1, 10'h155, 8'hA7);
        chk("t1_dirty", bus.dirty, 1'b0);

        // HPS read back
        hps_txn(1'b0, 10'h155, 8'h00);
        chk("t2_hps_dout", bus.hps_dout, 8'h07);

        // CPU priority: writes every cycle hold off the HPS write
        s_hps_req = 1; s_hps_we = 1; s_hps_addr = 10'h2AA; s_hps_din = 8'h05;
        s_cpu_cs = 1; s_cpu_we = 1; s_cpu_addr = 10'h010; s_cpu_din = 4'h3;
        repeat (10) run_cycle();
        chk("t3_no_launch", bus.busy, 1'b0);
        chk("t3_dirty", bus.dirty, 1'b1);
        s_cpu_cs = 0; s_cpu_we = 0;
        wait_ack(3);
        s_cpu_cs = 1; s_cpu_we = 0; s_cpu_addr = 10'h010;
        run_cycle();
        s_cpu_cs = 0;
        run_cycle();
        chk("t3_ram_010", bus.cpu_dout, 4'h3);

        // Starvation forces a pause after T wait cycles
        s_hps_req = 1; s_hps_we = 0; s_hps_addr = 10'h300;
        s_cpu_cs = 1; s_cpu_we = 1; s_cpu_addr = 10'h030; s_cpu_din = 4'h1;
        for (int i = 1; i <= T; i++) begin
            run_cycle();
            if (i == T - 1) chk("t4_pause_early", bus.cpu_pause, 1'b0);
        end
        chk("t4_pause_set", bus.cpu_pause, 1'b1);
        s_cpu_cs = 0; s_cpu_we = 0;
        wait_ack(4);
        chk("t4_pause_clr", bus.cpu_pause, 1'b0);

        // CPU read overlapping an HPS read
        s_cpu_cs = 1; s_cpu_we = 1; s_cpu_addr = 10'h020; s_cpu_din = 4'h9;
        run_cycle();
        s_cpu_cs = 0; s_cpu_we = 0;
        s_hps_req = 1; s_hps_we = 0; s_hps_addr = 10'h155;
        run_cycle();
        s_cpu_cs = 1; s_cpu_addr = 10'h020;
        run_cycle();
        s_cpu_cs = 0;
        run_cycle();
        s_hps_req = 0;
        run_cycle();
        chk("t5_cpu_dout", bus.cpu_dout, 4'h9);
        chk("t5_hps_dout", bus.hps_dout, 8'h07);

        // Dirty set/clear collision, plain clear, then reset during RDW
        s_clr = 1; s_cpu_cs = 1; s_cpu_we = 1; s_cpu_addr = 10'h040; s_cpu_din = 4'h2;
        run_cycle();
        s_cpu_cs = 0; s_cpu_we = 0;
        chk("t6_set_wins", bus.dirty, 1'b1);
        run_cycle();
        s_clr = 0;
        chk("t6_cleared", bus.dirty, 1'b0);
        s_cpu_cs = 1; s_cpu_we = 1;
        run_cycle();
        s_cpu_cs = 0; s_cpu_we = 0;
        s_hps_req = 1; s_hps_we = 0; s_hps_addr = 10'h2AA;
        run_cycle();
        chk("t6_in_rdw", bus.busy, 1'b1);
        apply_reset();
        chk("t6_no_ack", bus.hps_ack, 1'b0);
        chk("t6_idle", bus.busy, 1'b0);
        chk("t6_pause", bus.cpu_pause, 1'b0);
        chk("t6_dirty", bus.dirty, 1'b0);
        run_cycle();

        // hps_req drop before launch restarts the starvation count
        s_hps_req = 1; s_hps_we = 1; s_hps_addr = 10'h3F0; s_hps_din = 8'h0C;
        s_cpu_cs = 1; s_cpu_we = 0; s_cpu_addr = 10'h050;
        repeat (T / 2) run_cycle();
        s_hps_req = 0;
        run_cycle();
        s_hps_req = 1;
        repeat (T - 1) run_cycle();
        chk("drop_pause", bus.cpu_pause, 1'b0);
        s_cpu_cs = 0;
        wait_ack(3);

        // Randomized traffic against the reference model
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = ((i / 300) % 2) ? 90 : 35;
            s_cpu_cs   = ($urandom_range(99) < p);
            s_cpu_we   = 1'($urandom_range(1));
            s_cpu_addr = 10'($urandom_range(511));
            s_cpu_din  = 4'($urandom);
            s_clr      = ($urandom_range(19) == 0);
            if (!s_hps_req && $urandom_range(2) == 0) begin
                s_hps_req  = 1;
                s_hps_we   = 1'($urandom_range(1));
                s_hps_addr = 10'(512 + $urandom_range(511));
                s_hps_din  = 8'($urandom);
            end
            run_cycle();
            if (m_acked) s_hps_req = 0;
        end
        idle_inputs();
        repeat (4) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cmos_nvram_arbiter.md
Name: cmos_nvram_arbiter

Overview:
- Shares the single-port CMOS high-score/settings RAM (1K x 4, synchronous read) between two requesters:
  - the game CPU inside the Williams-2 core;
  - the HPS side, which saves and loads NVRAM through the ioctl path.
- The CPU always has priority.
- HPS word accesses are slotted into idle cycles through a req/ack handshake.
- A starvation timer forces a CPU pause if no idle slot appears.
- Tracks a dirty flag so the top level knows when an NVRAM save is warranted.
- Sits between the williams2 core's CMOS port and the RAM instance, in the 12 MHz system domain.

Parameters:
- AW, 10, RAM address width.
- DW, 4, RAM data width (CMOS nibble).
- HPS_TIMEOUT, 255, wait cycles before cpu_pause is forced; valid range 1..255.

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high reset.
- cpu_cs  in  1  CPU access this cycle.
- cpu_we  in  1  CPU write enable (qualified by cpu_cs).
- cpu_addr  in  AW  CPU address.
- cpu_din  in  DW  CPU write data.
- cpu_dout  out  DW  last CPU read data (registered).
- cpu_pause  out  1  request that the CPU halt its CMOS accesses.
- hps_req  in  1  HPS transaction request, level-held until ack.
- hps_we  in  1  1 = write, 0 = read.
- hps_addr  in  AW  HPS address.
- hps_din  in  8  HPS write data; only [DW-1:0] is stored.
- hps_dout  out  8  HPS read data, zero-extended.
- hps_ack  out  1  one-cycle completion pulse.
- hps_clr_dirty  in  1  pulse that clears dirty.
- ram_addr  out  AW  to RAM.
- ram_we  out  1  to RAM.
- ram_din  out  DW  to RAM.
- ram_dout  in  DW  from RAM; valid 1 cycle after address.
- dirty  out  1  CPU has written since the last clear.
- busy  out  1  HPS transaction in flight (state != IDLE).

Behaviour:
- **Reset values** (all registered outputs): cpu_dout=0, hps_dout=0, hps_ack=0, cpu_pause=0, dirty=0, busy=0. State=IDLE, wait counter=0.
- **Port mux** (combinational):
  - cpu_cs=1: ram_addr=cpu_addr, ram_we=cpu_we, ram_din=cpu_din. The CPU is never stalled by the arbiter.
  - else, in HPS launch cycle: ram_addr=hps_addr, ram_we=hps_we, ram_din=hps_din[DW-1:0].
  - else: ram_we=0, ram_addr=last HPS address.
- **CPU read path:** registered flag cpu_rd_d = cpu_cs & ~cpu_we. When cpu_rd_d=1, cpu_dout <= ram_dout. Read data is therefore valid 2 cycles after the cpu_cs read cycle and is held until the next CPU read.
- **State machine:**
  - IDLE: if hps_req & ~cpu_cs, this is the launch cycle. hps_we=1 -> ACK; hps_we=0 -> RDW. The wait counter clears.
  - IDLE with hps_req & cpu_cs: wait counter increments, saturating at HPS_TIMEOUT.
  - RDW: hps_dout <= {8-DW zeros, ram_dout} -> ACK. cpu_cs is permitted in this cycle.
  - ACK: hps_ack=1 for exactly this cycle -> IDLE, which cannot launch in the same cycle as ack. The requester presents its next request or deasserts by the next cycle.
- **Latency (no CPU contention):**
  - write: ack 1 cycle after launch;
  - read: ack 2 cycles after launch, with hps_dout valid in the ack cycle.
- **Starvation:**
  - cpu_pause is set when the counter reaches HPS_TIMEOUT with hps_req pending.
  - cpu_pause is cleared in the ACK cycle.
  - While paused, launch still requires cpu_cs=0; the CPU owns cpu_cs timing.
- **Dirty flag:**
  - set on any cycle with cpu_cs & cpu_we;
  - cleared on hps_clr_dirty;
  - if set and clear occur in the same cycle, set wins;
  - HPS writes do not set dirty.
- **hps_req drop:** if hps_req deasserts in IDLE before launch, the counter resets to 0 and cpu_pause drops. Once launched, a transaction always completes.
- **Reset mid-transaction:** any state -> IDLE, no ack is issued, cpu_pause=0. RAM contents are untouched apart from a write already presented in the current cycle.
- **Address wrap:** addresses are taken modulo 2^AW with no range checking.

Test Plan:
1. **HPS write, CPU idle.** Reset; hps_req=1, hps_we=1, hps_addr=0x155, hps_din=0xA7 -> ram_we=1 with ram_din=0x7 in the launch cycle; hps_ack 1 cycle later; dirty stays 0.
2. **HPS read, CPU idle.** RAM[0x155]=0x7, hps read -> hps_ack 2 cycles after launch with hps_dout=0x07; busy=1 from launch through the ack cycle.
3. **CPU priority.** cpu_cs=1, cpu_we=1, addr=0x010, din=0x3 every cycle for 10 cycles while hps_req is held -> no HPS launch; RAM[0x010]=0x3; dirty=1. Then cpu_cs=0 -> launch within 1 cycle.
4. **Starvation.** HPS_TIMEOUT=8 with cpu_cs held high and hps_req pending -> cpu_pause=1 after 8 wait cycles. Drop cpu_cs -> launch, then ack, and cpu_pause=0 in the ack cycle.
5. **CPU read during HPS read.** HPS read launched at cycle N; CPU read of 0x020 (=0x9) at N+1 -> hps_dout reflects the HPS address; cpu_dout=0x9 at N+3.
6. **Dirty set/clear collision, then reset.** hps_clr_dirty and a CPU write in the same cycle -> dirty=1. Assert reset in RDW -> state IDLE, no hps_ack, cpu_pause=0, dirty=0.
